// File: rtl/lz_denorm.sv
// Sequential denormalizer: restores the original fixed-point word from a
// normalized word and its leading-zero count by shifting right one bit per cycle.
//
// state | meaning
// IDLE  | ready for a new word/count pair
// SHIFT | right-shifting sr, cnt shifts remaining
// DONE  | result held on m_data/m_err until m_ready
module lz_denorm #(
  parameter int DATA_WIDTH = 16,
  parameter int ZERO_WIDTH = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_norm,
  input  logic [ZERO_WIDTH-1:0] s_zero_num,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [ZERO_WIDTH-1:0] K_FULL = ZERO_WIDTH'(DATA_WIDTH);
  localparam logic [ZERO_WIDTH-1:0] K_ONE  = ZERO_WIDTH'(1);
  localparam logic [ZERO_WIDTH-1:0] K_ZERO = '0;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] sr, sr_nxt;
  logic [ZERO_WIDTH-1:0] cnt, cnt_nxt;
  logic                  err, err_nxt;
  logic                  accept;

  assign s_ready = (state == IDLE);
  assign m_valid = (state == DONE);
  assign m_data  = sr;
  assign m_err   = err;
  assign accept  = s_valid && s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      sr    <= sr_nxt;
      cnt   <= cnt_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    cnt_nxt   = cnt;
    err_nxt   = err;
    case (state)
      IDLE: begin
        if (accept) begin
          if (s_zero_num == K_ZERO) begin
            sr_nxt    = s_norm;
            cnt_nxt   = K_ZERO;
            err_nxt   = ~s_norm[DATA_WIDTH-1];
            state_nxt = DONE;
          end else if (s_zero_num < K_FULL) begin
            sr_nxt    = s_norm;
            cnt_nxt   = s_zero_num;
            err_nxt   = ~s_norm[DATA_WIDTH-1];
            state_nxt = SHIFT;
          end else if (s_zero_num == K_FULL) begin
            // an all-zero original word must normalize to an all-zero word
            sr_nxt    = '0;
            cnt_nxt   = K_ZERO;
            err_nxt   = (s_norm != '0);
            state_nxt = DONE;
          end else begin
            sr_nxt    = '0;
            cnt_nxt   = K_ZERO;
            err_nxt   = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      SHIFT: begin
        sr_nxt  = {1'b0, sr[DATA_WIDTH-1:1]};
        cnt_nxt = cnt - K_ONE;
        if (cnt == K_ONE) state_nxt = DONE;
      end
      DONE: begin
        if (m_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lz_denorm.sv
// Self-checking bench for lz_denorm: directed corner cases, backpressure,
// mid-shift reset and a randomized normalize/denormalize round trip.
module tb_lz_denorm;
  localparam int DW = 16;
  localparam int ZW = $clog2(DW + 1);

  logic          clk;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_norm;
  logic [ZW-1:0] s_zero_num;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_err;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] q[$];

  lz_denorm #(.DATA_WIDTH(DW), .ZERO_WIDTH(ZW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_norm(s_norm), .s_zero_num(s_zero_num),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_err(m_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: original word is the normalized word shifted back by k.
  function automatic logic [DW-1:0] ref_data(input logic [DW-1:0] n, input int k);
    if (k >= DW) return '0;
    return n >> k;
  endfunction

  function automatic logic ref_err(input logic [DW-1:0] n, input int k);
    if (k < DW)  return ~n[DW-1];
    if (k == DW) return (n != 0);
    return 1'b1;
  endfunction

  function automatic int lzc(input logic [DW-1:0] x);
    for (int i = DW - 1; i >= 0; i--) if (x[i]) return DW - 1 - i;
    return DW;
  endfunction

  // Leaves the caller at the first falling edge after the accept edge.
  task automatic send(input logic [DW-1:0] n, input int k);
    int w;
    @(negedge clk);
    s_norm = n;
    s_zero_num = ZW'(k);
    s_valid = 1'b1;
    w = 0;
    while (!s_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) chk("send_timeout", 32'(w), 32'(0));
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    s_norm = DW'($urandom);
    s_zero_num = ZW'($urandom);
  endtask

  task automatic run_item(input string tag, input logic [DW-1:0] n, input int k);
    int lat;
    logic busy_ok;
    int exp_lat;
    exp_lat = (k == 0 || k >= DW) ? 0 : k;
    send(n, k);
    lat = 0;
    busy_ok = 1'b1;
    while (!m_valid && lat < 40) begin
      if (s_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy"}, 32'(busy_ok), 32'(1));
    chk({tag, "_data"}, 32'(m_data), 32'(ref_data(n, k)));
    chk({tag, "_err"}, 32'(m_err), 32'(ref_err(n, k)));
    m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_ready = 1'b0;
    chk({tag, "_release"}, {30'd0, m_valid, s_ready}, 32'b01);
  endtask

  initial begin
    logic stable;
    logic stale;
    int guard;
    rst_n = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    s_norm = '0;
    s_zero_num = '0;
    #12;
    chk("rst_m_valid", 32'(m_valid), 32'(0));
    chk("rst_m_data", 32'(m_data), 32'(0));
    chk("rst_m_err", 32'(m_err), 32'(0));
    chk("rst_s_ready", 32'(s_ready), 32'(1));
    @(negedge clk);
    rst_n = 1'b1;

    run_item("k0", 16'h8001, 0);
    run_item("k3", 16'hA000, 3);
    run_item("k16_zero", 16'h0000, 16);
    run_item("k16_bad", 16'h0004, 16);
    run_item("k17", 16'h1234, 17);
    run_item("k31", 16'hFFFF, 31);
    run_item("msb_bad", 16'h4000, 2);
    run_item("k15", 16'h8000, 15);
    run_item("k1", 16'hFFFF, 1);

    // Backpressure: result must hold while m_ready is low.
    send(16'hC000, 4);
    guard = 0;
    while (!m_valid && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk("bp_valid", 32'(m_valid), 32'(1));
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_norm = DW'($urandom);
      s_zero_num = ZW'($urandom);
      @(negedge clk);
      if (!(m_valid === 1'b1 && m_data === 16'h0C00 && m_err === 1'b0 && s_ready === 1'b0))
        stable = 1'b0;
    end
    chk("bp_stable", 32'(stable), 32'(1));
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_ready = 1'b0;
    chk("bp_release", {30'd0, m_valid, s_ready}, 32'b01);

    // Reset in the middle of a long shift drops the item.
    send(16'h8000, 10);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out", {13'd0, m_valid, m_err, m_data, s_ready}, {13'd0, 2'b00, 16'h0000, 1'b1});
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (m_valid !== 1'b0 || s_ready !== 1'b1) stale = 1'b1;
    end
    chk("midrst_nostale", 32'(stale), 32'(0));

    // Random round trip with random s_valid gaps and m_ready.
    for (int it = 0; it < 40; it++) begin
      logic [DW-1:0] x;
      logic [DW-1:0] expx;
      int k;
      int t;
      logic got;
      x = DW'($urandom_range(1, (1 << DW) - 1));
      k = lzc(x);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      q.push_back(x);
      send(x << k, k);
      got = 1'b0;
      t = 0;
      while (!got && t < 80) begin
        m_ready = 1'($urandom_range(0, 1));
        if (m_valid && m_ready) begin
          expx = q.pop_front();
          chk("rt_data", 32'(m_data), 32'(expx));
          chk("rt_err", 32'(m_err), 32'(0));
          got = 1'b1;
        end
        @(negedge clk);
        t++;
      end
      m_ready = 1'b0;
      if (!got) chk("rt_timeout", 32'(t), 32'(0));
    end
    chk("rt_drained", 32'(q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lz_denorm.md
# lz_denorm

Sequential denormalizer: the decode side of the team's leading-zero count path. It accepts a normalized word, with its leading one at the MSB, plus the leading-zero count produced upstream. It right-shifts the word one bit per cycle to restore the original value, then presents the result on a valid/ready output. It also flags malformed count/word pairs. It sits between the normalized-value store and consumers that need the original fixed-point word.

## Interface
- DATA_WIDTH, 16, width of data words (≥2)
- ZERO_WIDTH, $clog2(DATA_WIDTH+1), width of the zero-count field
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- s_valid  in  1  input word/count valid
- s_ready  out  1  block can accept (high only in IDLE)
- s_norm  in  DATA_WIDTH  normalized word
- s_zero_num  in  ZERO_WIDTH  leading-zero count of the original word
- m_valid  out  1  result valid
- m_ready  in  1  consumer accepts result
- m_data  out  DATA_WIDTH  denormalized word, registered
- m_err  out  1  malformed input flag, qualified by m_valid

## Operation
- States: IDLE, SHIFT, DONE. Registers: shift reg `sr` [DATA_WIDTH], down-counter `cnt` [ZERO_WIDTH], `err`.
- IDLE: s_ready=1. Acceptance is s_valid&&s_ready at a rising edge. On acceptance:
  - k = s_zero_num.
  - k==0: sr=s_norm; err=~s_norm[MSB]; go to DONE.
  - 1≤k≤DATA_WIDTH-1: sr=s_norm; cnt=k; err=~s_norm[MSB]; go to SHIFT.
  - k==DATA_WIDTH: sr=0; err=(s_norm!=0); go to DONE.
  - k>DATA_WIDTH: sr=0; err=1; go to DONE.
- SHIFT: each cycle sr = {1'b0, sr[DATA_WIDTH-1:1]} (logical, zero fill) and cnt = cnt-1. On the edge where cnt goes 1→0, go to DONE.
- DONE: m_valid=1, m_data=sr, m_err=err. On m_valid&&m_ready, go to IDLE.
- Single item in flight: s_ready=0 in SHIFT and DONE. There is no accept-on-release overlap: after the DONE handshake, the next accept is possible no earlier than the following edge.
- m_data and m_err must stay stable while m_valid=1 and m_ready=0.
- Bits shifted out are discarded. m_data equals s_norm >> k for legal k.
- An error never suppresses the output. A word is always delivered.

## Timing
- Reset (rst_n low, asynchronous, takes effect immediately):
  - state=IDLE; m_valid=0, m_data=0, m_err=0, cnt=0.
  - s_ready reads 1 while in IDLE, but no transfer occurs while rst_n=0.
- Latency, with acceptance at edge E0:
  - m_valid rises after E0 for k=0 or k≥DATA_WIDTH.
  - m_valid rises after edge E0+k for 1≤k≤DATA_WIDTH-1.
- Throughput: one result per k+2 cycles when m_ready is tied high (k shifts, one DONE cycle, one IDLE cycle).
- Reset mid-SHIFT or mid-DONE: the item is dropped and the block returns to IDLE with all outputs at their reset values. No partial result appears after release.
- m_ready high in a non-DONE state has no effect.
- s_valid may drop without acceptance. Inputs are sampled only at the accept edge, so s_norm/s_zero_num changes after acceptance are ignored.

## Test plan
- Zero count: k=0, s_norm=0x8001 -> m_valid one cycle after accept, m_data=0x8001, m_err=0.
- Legal shift: k=3, s_norm=0xA000 -> m_valid after edge E0+3, m_data=0x1400, m_err=0; s_ready=0 throughout SHIFT.
- All-zero and overflow counts:
  - k=16, s_norm=0 -> m_data=0, m_err=0, immediate.
  - k=16, s_norm=0x0004 -> m_data=0, m_err=1.
  - k=17 -> m_data=0, m_err=1.
- Malformed MSB: k=2, s_norm=0x4000 -> m_data=0x1000, m_err=1. Max legal shift: k=15, s_norm=0x8000 -> m_data=0x0001 after 15 shifts.
- Backpressure and reset:
  - Hold m_ready=0 for 5 cycles in DONE -> m_valid, m_data, m_err stable and s_ready=0; accept on release, then IDLE.
  - Assert rst_n=0 during SHIFT of k=10 -> outputs return to reset values at once; after release, no stale m_valid and s_ready=1.
- Random round trip: random nonzero x; k=leading-zero count of x; s_norm=x<<k. Drive with random m_ready and s_valid gaps -> m_data==x and m_err=0 for all items, with results in order.
